udp_channel_scheduler: RTL and testbench
========================================

Name: udp_channel_scheduler

Overview:
- Sequences readout of the per-channel byte-wide sample buffers into the UDP TX payload stream.
- One capture is a set of channel packets. Each packet is one header handshake, then BYTES_PER_CH payload bytes, then a wait for the MAC's tx_done.
- Sits between the six channel buffers (FWFT, byte output) and the UDP/Ethernet TX block.
- Drives the buffer read enables and the data-mux select.

Parameters:
- NUM_CH, 6: number of channel buffers.
- CH_W, 3: width of the addr select; must satisfy 2**CH_W >= NUM_CH.
- BYTES_PER_CH, 1024: payload bytes per packet; minimum 2.
- CNT_W, 16: byte counter width; must satisfy 2**CNT_W >= BYTES_PER_CH.

Ports:
- clk  in  1  single clock, 125 MHz domain
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to read out one capture
- ch_mask  in  NUM_CH  channel enable; sampled on accepted start
- full  in  NUM_CH  buffer full flags
- empty  in  NUM_CH  buffer empty flags; FWFT, so data is valid when !empty
- rd_en  out  NUM_CH  one-hot pop strobe to the selected buffer
- addr  out  CH_W  data-mux select (current channel index)
- hdr_valid  out  1  UDP header valid
- hdr_ready  in  1  UDP header accepted
- axis_tvalid  out  1  payload valid
- axis_tready  in  1  payload ready
- axis_tlast  out  1  last payload byte of the packet
- tx_done  in  1  MAC one-cycle pulse: packet fully transmitted
- busy  out  1  high in every state except IDLE
- capture_done  out  1  one-cycle pulse after the last packet's tx_done
- start_dropped  out  1  sticky; set when start arrives while busy; cleared by rst only

Behaviour:
- Reset (synchronous, any state): state=IDLE; byte counter=0; addr=0; mask register=0; all outputs 0.
- Reset mid-packet abandons the packet; no tlast is issued.
- IDLE:
  - start=1 and ch_mask!=0: latch mask; addr = lowest set mask bit; go to FILL.
  - start=1 and ch_mask==0: ignored, stay IDLE; start_dropped not set.
- FILL: wait until |full==1, then go to HDR.
- HDR:
  - hdr_valid=1 until the cycle with hdr_valid&hdr_ready, then go to PAYLOAD with count=0.
  - hdr_valid is never deasserted without a handshake.
- PAYLOAD:
  - axis_tvalid = !empty[addr], combinational from the state register.
  - rd_en[addr] = axis_tvalid & axis_tready; all other rd_en bits are 0.
  - Each transfer increments count.
  - axis_tlast = axis_tvalid & (count==BYTES_PER_CH-1).
  - On the tlast transfer go to WAIT_DONE.
  - Buffer empty mid-packet: tvalid low, count held; resume with no byte lost or duplicated.
  - tready low: rd_en low, count held.
- WAIT_DONE: hold all strobes 0 until tx_done=1, then go to NEXT.
- NEXT (1 cycle):
  - Clear the current bit from the mask register.
  - Remaining mask nonzero: addr = lowest remaining set bit; go to HDR. No re-wait on full.
  - Remaining mask zero: pulse capture_done, addr=0, go to IDLE.
- Latency:
  - hdr_valid rises 1 cycle after |full is seen in FILL.
  - First payload byte can be presented 1 cycle after the header handshake.
  - The next channel's hdr_valid rises 2 cycles after tx_done.
- Simultaneous events:
  - start while busy: ignored, start_dropped=1, current sequence unaffected.
  - tx_done outside WAIT_DONE: ignored.
  - start in the same cycle capture_done pulses: the FSM is still busy, so start is dropped.
- Invariants:
  - rd_en is at most one-hot and only nonzero in PAYLOAD.
  - addr is stable from HDR through WAIT_DONE.
  - Exactly BYTES_PER_CH transfers per packet.
  - Exactly one tlast per packet.

Test Plan:
1. BYTES_PER_CH=4, ch_mask=6'b111111, all buffers full and non-empty, tready=1, start pulse, tx_done 5 cycles after each tlast -> 6 packets in order, addr=0,1,2,3,4,5; 4 transfers each with tlast on the 4th; capture_done pulses once after the 6th tx_done.
2. ch_mask=6'b100101 -> only addr 0, 2, 5 serviced; rd_en[1,3,4] never asserted; 3 header handshakes total.
3. tready toggled 1,0,0,1 repeating, and empty[addr] forced high for 3 cycles mid-packet -> no rd_en while tvalid or tready is low; count holds; still exactly 4 pops per packet; data order preserved.
4. hdr_ready held low for 10 cycles -> hdr_valid stays high throughout; no payload tvalid before the handshake.
5. start pulsed during PAYLOAD of channel 2 -> sequence unchanged; start_dropped=1 and stays set. start with ch_mask=0 in IDLE -> busy stays 0.
6. rst asserted during PAYLOAD at count=2 -> next cycle state=IDLE and all outputs 0; a fresh start produces a normal full sequence from addr 0.

Source files
------------

// File: rtl/udp_channel_scheduler.sv
// udp_channel_scheduler: reads the per-channel FWFT sample buffers out as UDP payload.
// Each masked channel becomes one packet: a header handshake, BYTES_PER_CH payload
// bytes, then a wait for the MAC's tx_done before the next channel.
module udp_channel_scheduler #(
   parameter int NUM_CH       = 6,
   parameter int CH_W         = 3,
   parameter int BYTES_PER_CH = 1024,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic [NUM_CH-1:0] full,
   input  logic [NUM_CH-1:0] empty,
   output logic [NUM_CH-1:0] rd_en,
   output logic [CH_W-1:0]   addr,
   output logic              hdr_valid,
   input  logic              hdr_ready,
   output logic              axis_tvalid,
   input  logic              axis_tready,
   output logic              axis_tlast,
   input  logic              tx_done,
   output logic              busy,
   output logic              capture_done,
   output logic              start_dropped
);

   typedef enum logic [2:0] {IDLE, FILL, HDR, PAYLOAD, WAIT_DONE, NEXT} state_t;

   state_t            state;
   logic [CNT_W-1:0]  count;
   logic [NUM_CH-1:0] mask;
   logic [NUM_CH-1:0] cur_bit;
   logic [NUM_CH-1:0] rem;
   logic              xfer;
   logic              last_byte;

   // Index of the lowest set bit; callers only pass nonzero masks.
   function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
      lowest = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i]) lowest = CH_W'(i);
   endfunction

   // Channels still owed a packet once the current one is retired.
   assign cur_bit   = NUM_CH'(1) << addr;
   assign rem       = mask & ~cur_bit;

   // Payload handshake is decoded straight from the state register so a
   // buffer going empty stalls the stream in the same cycle.
   assign busy        = (state != IDLE);
   assign axis_tvalid = (state == PAYLOAD) && !empty[addr];
   assign xfer        = axis_tvalid && axis_tready;
   assign last_byte   = (count == CNT_W'(BYTES_PER_CH - 1));
   assign axis_tlast  = axis_tvalid && last_byte;

   // Pop only the selected buffer, and only on an accepted byte.
   always_comb begin
      rd_en = '0;
      if (xfer) rd_en[addr] = 1'b1;
   end

   // Sequencer: capture -> per-channel header/payload/tx_done loop -> idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         count         <= '0;
         mask          <= '0;
         addr          <= '0;
         hdr_valid     <= 1'b0;
         capture_done  <= 1'b0;
         start_dropped <= 1'b0;
      end else begin
         capture_done <= 1'b0;
         if (start && state != IDLE) start_dropped <= 1'b1;
         case (state)
            IDLE: begin
               if (start && |ch_mask) begin
                  mask  <= ch_mask;
                  addr  <= lowest(ch_mask);
                  state <= FILL;
               end
            end
            FILL: begin
               if (|full) begin
                  hdr_valid <= 1'b1;
                  state     <= HDR;
               end
            end
            HDR: begin
               // hdr_valid stays up until the TX block takes the header.
               if (hdr_ready) begin
                  hdr_valid <= 1'b0;
                  count     <= '0;
                  state     <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (xfer) begin
                  if (last_byte) begin
                     count <= '0;
                     state <= WAIT_DONE;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            WAIT_DONE: begin
               // Raise capture_done while NEXT retires the final channel, so
               // the FSM is still busy during the pulse.
               if (tx_done) begin
                  capture_done <= (rem == '0);
                  state        <= NEXT;
               end
            end
            NEXT: begin
               mask <= rem;
               if (|rem) begin
                  addr      <= lowest(rem);
                  hdr_valid <= 1'b1;
                  state     <= HDR;
               end else begin
                  addr  <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_channel_scheduler.sv
// Directed bench for udp_channel_scheduler with 4-byte packets.
module tb_udp_channel_scheduler;

   localparam int NCH = 6;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [NCH-1:0] ch_mask = '0;
   logic [NCH-1:0] full = '0;
   logic [NCH-1:0] empty = '1;
   logic [NCH-1:0] rd_en;
   logic [2:0]     addr;
   logic           hdr_valid;
   logic           hdr_ready = 1'b1;
   logic           axis_tvalid;
   logic           axis_tready = 1'b1;
   logic           axis_tlast;
   logic           tx_done = 1'b0;
   logic           busy;
   logic           capture_done;
   logic           start_dropped;

   udp_channel_scheduler #(.NUM_CH(6), .CH_W(3), .BYTES_PER_CH(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .full(full), .empty(empty),
      .rd_en(rd_en), .addr(addr), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
      .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tlast(axis_tlast),
      .tx_done(tx_done), .busy(busy), .capture_done(capture_done),
      .start_dropped(start_dropped)
   );

   always #4 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Monitor state, updated at each falling edge.
   int hdr_cnt, tl_cnt, cap_cnt, viol, pops_total, pkt_pops;
   int pops [NCH];
   int hdr_order [$];
   logic [NCH-1:0] exp_rd;
   int tr_mode = 0;
   bit tr_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic clr_mon();
      hdr_cnt = 0; tl_cnt = 0; cap_cnt = 0; viol = 0; pops_total = 0; pkt_pops = 0;
      for (int i = 0; i < NCH; i++) pops[i] = 0;
      hdr_order.delete();
   endtask

   task automatic pulse_start(input logic [NCH-1:0] m);
      tick();
      start = 1'b1; ch_mask = m;
      tick();
      start = 1'b0; ch_mask = '0;
   endtask

   task automatic wait_cap(input string tag);
      int c = 0;
      while (cap_cnt == 0 && c < 2000) begin sample(); c++; end
      chk({tag, "_cap_timeout"}, (cap_cnt == 0), 0);
   endtask

   task automatic wait_pops(input string tag, input int n);
      int c = 0;
      while (pops_total < n && c < 500) begin sample(); c++; end
      chk({tag, "_pop_timeout"}, (pops_total < n), 0);
   endtask

   task automatic chk_order(input string tag, input int exp []);
      chk({tag, "_hdrs"}, hdr_cnt, exp.size());
      for (int i = 0; i < exp.size(); i++)
         chk($sformatf("%s_order%0d", tag, i),
             (i < hdr_order.size()) ? hdr_order[i] : -1, exp[i]);
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_hdr_valid"}, hdr_valid, 0);
      chk({tag, "_tvalid"}, axis_tvalid, 0);
      chk({tag, "_tlast"}, axis_tlast, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_addr"}, addr, 0);
      chk({tag, "_cap"}, capture_done, 0);
   endtask

   // Protocol monitor: counts handshakes/pops and flags rule breaks.
   always @(negedge clk) begin
      if (!rst) begin
         if (hdr_valid && hdr_ready) begin
            hdr_cnt++;
            hdr_order.push_back(int'(addr));
            pkt_pops = 0;
         end
         exp_rd = (axis_tvalid && axis_tready) ? (NCH'(1) << addr) : '0;
         if (rd_en !== exp_rd) viol++;
         if (axis_tvalid && empty[addr]) viol++;
         if (hdr_valid && axis_tvalid) viol++;
         if (axis_tvalid && axis_tready) begin
            pops[addr]++;
            pops_total++;
            if (axis_tlast !== (pkt_pops == 3)) viol++;
            if (axis_tlast) tl_cnt++;
            pkt_pops++;
         end else if (axis_tlast && !axis_tvalid) begin
            viol++;
         end
         if (capture_done) cap_cnt++;
      end
   end

   // MAC model: tx_done pulse 5 cycles after each tlast transfer.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && axis_tvalid && axis_tready && axis_tlast) begin
            repeat (5) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
         end
      end
   end

   // Payload ready driver: always ready, or the 1,0,0,1 pattern.
   initial begin
      int ph = 0;
      forever begin
         @(posedge clk);
         #1;
         if (tr_mode != 0) begin
            axis_tready = tr_pat[ph];
            ph = (ph + 1) % 4;
         end else begin
            axis_tready = 1'b1;
            ph = 0;
         end
      end
   end

   initial begin
      clr_mon();
      // Reset state
      rst = 1'b1;
      tick(); tick();
      sample();
      chk_idle_outs("rst");
      chk("rst_dropped", start_dropped, 0);
      tick();
      rst = 1'b0;
      full = '1; empty = '0;

      // 1: all six channels, header latency after full
      clr_mon();
      pulse_start(6'b111111);
      chk("t1_busy", busy, 1);
      chk("t1_fill_hdr", hdr_valid, 0);
      tick();
      chk("t1_hdr_rise", hdr_valid, 1);
      chk("t1_addr0", addr, 0);
      wait_cap("t1");
      chk_order("t1", '{0, 1, 2, 3, 4, 5});
      for (int i = 0; i < NCH; i++) chk($sformatf("t1_pops%0d", i), pops[i], 4);
      chk("t1_tlast", tl_cnt, 6);
      repeat (4) sample();
      chk("t1_cap_once", cap_cnt, 1);
      chk("t1_idle", busy, 0);
      chk("t1_viol", viol, 0);

      // 2: sparse mask
      clr_mon();
      pulse_start(6'b100101);
      wait_cap("t2");
      chk_order("t2", '{0, 2, 5});
      chk("t2_pops1", pops[1], 0);
      chk("t2_pops3", pops[3], 0);
      chk("t2_pops4", pops[4], 0);
      chk("t2_pops5", pops[5], 4);
      chk("t2_viol", viol, 0);

      // 3: tready pattern plus a 3-cycle empty stall mid-packet
      clr_mon();
      tr_mode = 1;
      pulse_start(6'b000011);
      wait_pops("t3", 2);
      tick();
      empty = '1;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk($sformatf("t3_stall_tvalid%0d", i), axis_tvalid, 0);
         chk($sformatf("t3_stall_rd%0d", i), rd_en, 0);
         tick();
      end
      empty = '0;
      chk("t3_stall_pops", pops_total, 2);
      wait_cap("t3");
      tr_mode = 0;
      chk("t3_pops0", pops[0], 4);
      chk("t3_pops1", pops[1], 4);
      chk("t3_tlast", tl_cnt, 2);
      chk("t3_viol", viol, 0);

      // 4: header back-pressure
      clr_mon();
      hdr_ready = 1'b0;
      pulse_start(6'b000001);
      tick();
      for (int i = 0; i < 10; i++) begin
         sample();
         chk($sformatf("t4_hv%0d", i), hdr_valid, 1);
         chk($sformatf("t4_tv%0d", i), axis_tvalid, 0);
         tick();
      end
      hdr_ready = 1'b1;
      wait_cap("t4");
      chk("t4_hdrs", hdr_cnt, 1);
      chk("t4_pops0", pops[0], 4);
      chk("t4_viol", viol, 0);

      // 5: start while busy is dropped; empty mask start is ignored
      clr_mon();
      pulse_start(6'b000111);
      begin
         int c = 0;
         while (!(addr == 2 && axis_tvalid) && c < 500) begin sample(); c++; end
         chk("t5_reach_ch2", (addr == 2 && axis_tvalid), 1);
      end
      chk("t5_pre_dropped", start_dropped, 0);
      pulse_start(6'b111111);
      chk("t5_dropped", start_dropped, 1);
      wait_cap("t5");
      chk_order("t5", '{0, 1, 2});
      pulse_start(6'b000000);
      for (int i = 0; i < 3; i++) begin
         sample();
         chk($sformatf("t5_zero_busy%0d", i), busy, 0);
      end
      chk("t5_dropped_sticky", start_dropped, 1);
      chk("t5_viol", viol, 0);

      // 6: reset mid-packet, then a full fresh capture
      clr_mon();
      pulse_start(6'b000001);
      wait_pops("t6", 2);
      tick();
      rst = 1'b1;
      tick();
      sample();
      chk_idle_outs("t6_rst");
      chk("t6_rst_dropped", start_dropped, 0);
      chk("t6_no_tlast", tl_cnt, 0);
      tick();
      rst = 1'b0;
      clr_mon();
      pulse_start(6'b111111);
      chk("t6_addr0", addr, 0);
      wait_cap("t6");
      chk_order("t6", '{0, 1, 2, 3, 4, 5});
      chk("t6_tlast", tl_cnt, 6);
      chk("t6_viol", viol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
